// File: rtl/kp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kp_pkg
//  Description : Shared types and constants for the kp_frame_sequencer block.
//                Holds the sequencer state encoding, the number of padding
//                rows appended after each frame, and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package kp_pkg;

  // Sequencer states, explicitly encoded on 2 bits.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } kp_state_t;

  // Padding rows emitted after the last real line of a frame.
  localparam int FLUSH_ROWS = 2;

  // Bit width for a counter covering 0..n-1; never narrower than one bit so
  // degenerate 1-pixel / 1-line configurations still elaborate.
  function automatic int kp_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : kp_pkg
`default_nettype wire

// File: rtl/kp_pixel_counter.sv
`default_nettype none
// ============================================================================
//  Module      : kp_pixel_counter
//  Description : Column/row raster counter. Column wraps COLS-1 -> 0 and
//                bumps the row; row wraps ROWS-1 -> 0. Advances only when
//                i_en is high; i_clr returns both counters to zero.
//  Ports       : i_clk       clock, rising edge
//                i_rst       synchronous active-high reset
//                i_clr       synchronous clear of both counters
//                i_en        advance by one position
//                o_col/o_row current column / row
//                o_last_col  column is COLS-1
//                o_last_row  row is ROWS-1
//  Revision    : 1.0 - initial release
// ============================================================================
module kp_pixel_counter #(
  parameter int COLS = 48,
  parameter int ROWS = 50,
  parameter int CW   = 6,
  parameter int RW   = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last_col,
  output logic          o_last_row
);

  localparam logic [CW-1:0] c_last_col = CW'(COLS - 1);
  localparam logic [RW-1:0] c_last_row = RW'(ROWS - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_last_col;
  logic          w_last_row;

  assign w_last_col = (r_col == c_last_col);
  assign w_last_row = (r_row == c_last_row);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_last_col = w_last_col;
  assign o_last_row = w_last_row;

endmodule : kp_pixel_counter
`default_nettype wire

// File: rtl/kp_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : kp_frame_sequencer
//  Description : Streams one frame of LINE_COUNT x LINE_LENGTH pixels from an
//                FWFT FIFO to kernel control, then appends FLUSH_ROWS rows of
//                PAD_VALUE so downstream line buffers drain. One beat per
//                cycle when the consumer requests (and, while streaming, the
//                FIFO is non-empty). Pixel outputs are registered (latency 1).
//  Ports       : i_clk, i_rst             clock / sync active-high reset
//                i_start                  frame start pulse
//                o_busy, o_done, o_err    status (o_err sticky)
//                i_fifo_data/i_fifo_empty upstream FIFO head / empty
//                o_fifo_rd                upstream pop (combinational)
//                i_kc_req                 kernel-control request
//                o_kc_data, o_kc_valid    pixel and its valid
//                o_sof, o_eol, o_eof      start-of-frame / end-of-line /
//                                         end-of-flush qualifiers
//  Revision    : 1.0 - initial release
// ============================================================================
module kp_frame_sequencer
  import kp_pkg::*;
#(
  parameter int                    LINE_LENGTH = 48,
  parameter int                    LINE_COUNT  = 48,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  input  logic                  i_kc_req,
  output logic [DATA_WIDTH-1:0] o_kc_data,
  output logic                  o_kc_valid,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_eof
);

  localparam int TOTAL_ROWS = LINE_COUNT + FLUSH_ROWS;
  localparam int CW         = kp_cnt_w(LINE_LENGTH);
  localparam int RW         = kp_cnt_w(TOTAL_ROWS);

  localparam logic [RW-1:0] c_last_stream_row = RW'(LINE_COUNT - 1);

  kp_state_t r_state;
  kp_state_t w_next_state;

  logic          w_beat;
  logic          w_fifo_rd;
  logic          w_busy;
  logic          w_start_ok;
  logic          w_start_err;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last_col;
  logic          w_last_row;

  logic [DATA_WIDTH-1:0] r_kc_data;
  logic                  r_kc_valid;
  logic                  r_sof;
  logic                  r_eol;
  logic                  r_eof;
  logic                  r_done;
  logic                  r_err;

  // The row counter spans both the real lines and the flush rows, so a
  // single raster position identifies every beat of the frame.
  kp_pixel_counter #(
    .COLS (LINE_LENGTH),
    .ROWS (TOTAL_ROWS),
    .CW   (CW),
    .RW   (RW)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_start_ok),
    .i_en       (w_beat),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_beat && w_last_col && (w_row == c_last_stream_row)) begin
          w_next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_beat && w_last_col && w_last_row) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State-decoded outputs. A start in DONE is simply dropped: the frame has
  // finished, so it is not treated as a collision.
  // -------------------------------------------------------------------------
  always_comb begin
    w_beat      = 1'b0;
    w_fifo_rd   = 1'b0;
    w_busy      = 1'b0;
    w_start_ok  = 1'b0;
    w_start_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start_ok = i_start;
      end
      ST_STREAM: begin
        w_busy      = 1'b1;
        w_fifo_rd   = i_kc_req & ~i_fifo_empty;
        w_beat      = w_fifo_rd;
        w_start_err = i_start;
      end
      ST_FLUSH: begin
        w_busy      = 1'b1;
        w_beat      = i_kc_req;
        w_start_err = i_start;
      end
      ST_DONE: begin
        w_busy = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Gate the pop with reset so a word is never consumed by a frame that the
  // same edge is aborting.
  assign o_fifo_rd = w_fifo_rd & ~i_rst;
  assign o_busy    = w_busy;

  // -------------------------------------------------------------------------
  // Registered pixel stream and status
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kc_data  <= '0;
      r_kc_valid <= 1'b0;
      r_sof      <= 1'b0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_kc_valid <= w_beat;
      if (w_beat) begin
        r_kc_data <= (r_state == ST_STREAM) ? i_fifo_data : PAD_VALUE;
      end
      r_sof  <= w_beat && (r_state == ST_STREAM) && (w_col == '0) && (w_row == '0);
      r_eol  <= w_beat && w_last_col;
      r_eof  <= w_beat && (r_state == ST_FLUSH) && w_last_col && w_last_row;
      // o_done follows the cycle spent in DONE, i.e. one cycle after o_eof.
      r_done <= (r_state == ST_DONE);
      if (w_start_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_kc_data  = r_kc_data;
  assign o_kc_valid = r_kc_valid;
  assign o_sof      = r_sof;
  assign o_eol      = r_eol;
  assign o_eof      = r_eof;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule : kp_frame_sequencer
`default_nettype wire

// File: doc/kp_frame_sequencer.md
KP_FRAME_SEQUENCER -- requirements
Module: kp_frame_sequencer

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 48, pixels per line.
REQ-002 SHALL have parameter LINE_COUNT, default 48, lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, pixel width.
REQ-004 SHALL have parameter PAD_VALUE, default 0, flush pixel value.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-006 i_clk  in  1  sole clock, rising edge.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_start  in  1  one-cycle pulse that begins a frame.
REQ-009 o_busy  out  1  high from the cycle after an accepted start until o_done.
REQ-010 o_done  out  1  one-cycle pulse at frame completion.
REQ-011 o_err  out  1  sticky; set by i_start while busy.
REQ-012 i_fifo_data  in  DATA_WIDTH  upstream FWFT FIFO head word.
REQ-013 i_fifo_empty  in  1  upstream FIFO empty.
REQ-014 o_fifo_rd  out  1  upstream pop, combinational.
REQ-015 i_kc_req  in  1  kernel-control ready/request.
REQ-016 o_kc_data  out  DATA_WIDTH  pixel to kernel control.
REQ-017 o_kc_valid  out  1  o_kc_data valid, one beat per cycle.
REQ-018 o_sof / o_eol / o_eof  out  1 each  qualifiers on o_kc_valid: first pixel of frame / last pixel of each line / last pixel of flush.

Function
REQ-019 SHALL implement FSM IDLE, STREAM, FLUSH, DONE.
REQ-020 IDLE: i_start -> STREAM; column and row counters cleared.
REQ-021 STREAM: o_fifo_rd = i_kc_req & ~i_fifo_empty; each pop is one beat.
REQ-022 FLUSH: beat = i_kc_req; FIFO not read; data = PAD_VALUE.
REQ-023 o_kc_valid/o_kc_data/qualifiers SHALL be registered, asserted the cycle after the beat (latency 1).
REQ-024 Column counter SHALL wrap LINE_LENGTH-1 -> 0 and increment the row counter on wrap.
REQ-025 Last beat of row LINE_COUNT-1 SHALL move STREAM -> FLUSH.
REQ-026 FLUSH SHALL emit exactly 2 rows (FLUSH_ROWS) of LINE_LENGTH beats, then -> DONE.
REQ-027 DONE SHALL pulse o_done for one cycle and return to IDLE; total beats per frame = LINE_LENGTH*(LINE_COUNT+2).
REQ-028 FIFO empty or i_kc_req low SHALL stall with no beat and unchanged counters; o_kc_valid low the next cycle.
REQ-029 i_start outside IDLE SHALL be ignored and set o_err.
REQ-030 i_start in the DONE cycle SHALL be ignored without setting o_err.
REQ-031 Counter widths SHALL be $clog2 of LINE_LENGTH and of LINE_COUNT+2.

Reset
REQ-032 i_rst SHALL force IDLE, counters 0, and o_busy, o_done, o_err, o_fifo_rd, o_kc_valid, o_sof, o_eol, o_eof low, o_kc_data 0.
REQ-033 Reset mid-frame SHALL abort without an o_done pulse; the next i_start begins a fresh frame with o_sof.
REQ-034 Reset has priority over i_start in the same cycle.

Structure
REQ-035 Package kp_pkg SHALL hold the FSM state enum and the FLUSH_ROWS=2 constant.
REQ-036 Sub-module kp_pixel_counter (column/row wrap counter, enable input, last-column/last-row flags) SHALL be used.

Verification (LINE_LENGTH=4, LINE_COUNT=3)
REQ-037 Start; FIFO holds 12 words 1..12; i_kc_req=1 -> 20 valids: 1..12 then 8 zeros; o_sof on 1; o_eol on 4,8,12 and the 4th/8th pad; o_eof on the 20th; o_done 1 cycle after it.
REQ-038 FIFO empty for 3 cycles after the 5th word -> no valids and no pops for those cycles; sequence resumes at 6; totals unchanged.
REQ-039 i_kc_req toggled every cycle -> o_fifo_rd never high while i_kc_req is low; 20 beats delivered.
REQ-040 i_start pulsed in STREAM -> o_err=1 and stays 1; frame completes normally.
REQ-041 i_rst after the 7th beat -> all outputs 0 next cycle, no o_done; restart yields o_sof on the next FIFO word.
REQ-042 PAD_VALUE=16'hABCD -> all 8 flush beats carry 16'hABCD; o_fifo_rd low throughout FLUSH.
